// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and the MEM-stage load/store.
// Define MEM_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles and flag a sticky timeout error.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              sys_clk_i,
   input  logic              rst_n_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              mem_rd_i,
   input  logic              mem_wr_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              mem_valid_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [DATA_W-1:0] bus_rdata_i,
   output logic              stall_if_o,
   output logic              stall_mem_o,
   output logic              timeout_err_o
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   logic [1:0]        state;
   logic              own_if;
   logic              mem_any;
   logic              to_hit;
   logic              load_rdata;
   logic [DATA_W-1:0] resp_data;
   assign mem_any    = mem_rd_i | mem_wr_i;
   // A timeout loads zero into the owner's rdata even for a write; a real ack never updates it for writes.
   assign resp_data  = bus_rvalid_i ? bus_rdata_i : '0;
   assign load_rdata = ~bus_rvalid_i | ~bus_we_o;
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= IDLE;
         own_if      <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_any) begin
                  state       <= REQ;
                  own_if      <= 1'b0;
                  bus_we_o    <= mem_wr_i;
                  bus_addr_o  <= mem_addr_i;
                  bus_wdata_o <= mem_wdata_i;
               end else if (if_req_i) begin
                  state       <= REQ;
                  own_if      <= 1'b1;
                  bus_we_o    <= 1'b0;
                  bus_addr_o  <= if_addr_i;
                  bus_wdata_o <= '0;
               end
            end
            REQ: if (bus_gnt_i) state <= WAIT;
            WAIT: begin
               if (bus_rvalid_i || to_hit) begin
                  state <= DONE;
                  if (load_rdata && own_if) if_rdata_o <= resp_data;
                  if (load_rdata && !own_if) mem_rdata_o <= resp_data;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] to_cnt;
   logic            to_err;
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         to_cnt <= '0;
         to_err <= 1'b0;
      end else begin
         if (state == REQ && bus_gnt_i) to_cnt <= '0;
         else if (state == WAIT) to_cnt <= to_cnt + 1'b1;
         if (to_hit && !bus_rvalid_i) to_err <= 1'b1;
      end
   end
   // The last WAIT cycle is the TIMEOUT_CYC-th one, so the count compares against TIMEOUT_CYC-1.
   assign to_hit        = (state == WAIT) && (to_cnt == TO_LAST);
   assign timeout_err_o = to_err;
`else
   assign to_hit        = TIMEOUT_CYC < 0;
   assign timeout_err_o = 1'b0;
`endif
   assign bus_req_o   = state == REQ;
   assign if_valid_o  = (state == DONE) & own_if;
   assign mem_valid_o = (state == DONE) & ~own_if;
   assign stall_mem_o = mem_any & ~mem_valid_o;
   assign stall_if_o  = if_req_i & ~if_valid_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus transaction scoreboard for mem_port_arbiter, with reset and timeout sequences.
module tb_mem_port_arbiter;
   localparam int TO = 8;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
   logic        if_valid, mem_valid, bus_req, bus_we, stall_if, stall_mem, timeout_err;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] m_if = '0, m_mem = '0;
   typedef struct {
      logic ifr; logic [31:0] ia; logic rd; logic wr; logic [31:0] ma; logic [31:0] wd;
      int gdly; logic [31:0] irsp; logic [31:0] mrsp; int cyc;
   } vec_t;
   typedef struct {logic own_if; logic [31:0] addr; logic we; logic [31:0] wdata; logic [31:0] rsp;} txn_t;
   txn_t sb[$];
   txn_t cur = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
   vec_t vt[7];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .sys_clk_i(clk), .rst_n_i(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
      .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_rdata_o(mem_rdata), .mem_valid_o(mem_valid),
      .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
      .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem), .timeout_err_o(timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, bus_req, 0);
      chk({tag, "_we"}, bus_we, 0);
      chk({tag, "_addr"}, bus_addr, 0);
      chk({tag, "_wdata"}, bus_wdata, 0);
      chk({tag, "_if_rdata"}, if_rdata, 0);
      chk({tag, "_mem_rdata"}, mem_rdata, 0);
      chk({tag, "_if_valid"}, if_valid, 0);
      chk({tag, "_mem_valid"}, mem_valid, 0);
      chk({tag, "_terr"}, timeout_err, 0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int ph = 0, cnt = 0, n = 0, last = 0;
      logic g = 1'b0, rv = 1'b0, pulse;
      if (v.rd | v.wr) sb.push_back('{1'b0, v.ma, v.wr, v.wd, v.mrsp});
      if (v.ifr) sb.push_back('{1'b1, v.ia, 1'b0, 32'h0, v.irsp});
      @(negedge clk);
      if_req = v.ifr; if_addr = v.ia; mem_rd = v.rd; mem_wr = v.wr; mem_addr = v.ma; mem_wdata = v.wd;
      while ((sb.size() > 0 || ph != 0) && n < 200) begin
         @(negedge clk);
         n++;
         pulse = ph == 2;
         chk({tag, "_if_valid"}, if_valid, pulse && cur.own_if);
         chk({tag, "_mem_valid"}, mem_valid, pulse && !cur.own_if);
         chk({tag, "_stall_if"}, stall_if, if_req && !(pulse && cur.own_if));
         chk({tag, "_stall_mem"}, stall_mem, (mem_rd | mem_wr) && !(pulse && !cur.own_if));
         case (ph)
            0: if (bus_req) begin
               chk({tag, "_unexpected_txn"}, sb.size() > 0, 1);
               if (sb.size() > 0) cur = sb.pop_front();
               chk({tag, "_bus_addr"}, bus_addr, cur.addr);
               chk({tag, "_bus_we"}, bus_we, cur.we);
               chk({tag, "_bus_wdata"}, bus_wdata, cur.wdata);
               cnt = v.gdly; g = cnt == 0; ph = 1;
            end
            1: if (g) begin
               chk({tag, "_req_drop"}, bus_req, 0);
               g = 1'b0; rv = 1'b1; ph = 2;
            end else begin
               chk({tag, "_req_hold"}, bus_req, 1);
               chk({tag, "_addr_hold"}, bus_addr, cur.addr);
               chk({tag, "_wdata_hold"}, bus_wdata, cur.wdata);
               cnt--; g = cnt == 0;
            end
            default: begin
               if (!cur.we && cur.own_if) m_if = cur.rsp;
               if (!cur.we && !cur.own_if) m_mem = cur.rsp;
               chk({tag, "_if_rdata"}, if_rdata, m_if);
               chk({tag, "_mem_rdata"}, mem_rdata, m_mem);
               if (cur.own_if) if_req = 1'b0;
               else begin mem_rd = 1'b0; mem_wr = 1'b0; end
               rv = 1'b0; last = n; ph = 0;
            end
         endcase
         bus_gnt = g; bus_rvalid = rv; bus_rdata = rv ? cur.rsp : 32'hDEAD_BEEF;
      end
      chk({tag, "_budget"}, n < 200, 1);
      chk({tag, "_latency"}, last, v.cyc);
      sb.delete();
      repeat (2) begin
         @(negedge clk);
         chk({tag, "_idle_req"}, bus_req, 0);
         chk({tag, "_idle_terr"}, timeout_err, 0);
      end
   endtask

   task automatic start_and_grant(input string tag);
      int n = 0;
      while (!bus_req && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_req_seen"}, bus_req, 1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk({tag, "_in_wait"}, bus_req, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0051_3023, 32'h0, 3};
      vt[1] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h00A0_0093, 32'h1111_2222, 7};
      vt[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 4, 32'h0, 32'h5555_6666, 7};
      vt[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'h0BAD_F00D, 1, 32'h0, 32'h7777_8888, 4};
      vt[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 2, 32'h0, 32'h1234_5678, 5};
      vt[5] = '{1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0, 2, 32'h9ABC_DEF0, 32'h0, 5};
      vt[6] = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0013, 32'h0, 3};
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));
      // Reset while a fetch sits in WAIT, then a stale response arrives.
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      start_and_grant("rstwait");
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      if_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_rvalid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk_all_zero("post_rst");
      end
      m_if = '0; m_mem = '0;
      run_vec(vt[6], "after_rst");
      @(negedge clk);
      mem_rd = 1'b1; mem_addr = 32'h500;
      start_and_grant("tmo");
`ifdef MEM_ARB_TIMEOUT_EN
      for (int w = 1; w <= 12; w++) begin
         @(negedge clk);
         chk("tmo_valid", mem_valid, w == TO);
         chk("tmo_err", timeout_err, w >= TO);
         if (w == TO) begin
            chk("tmo_rdata", mem_rdata, 0);
            mem_rd = 1'b0;
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // A response on the final WAIT cycle must win over the timeout.
      @(negedge clk);
      mem_rd = 1'b1; mem_addr = 32'h600;
      start_and_grant("tie");
      for (int w = 1; w <= 10; w++) begin
         @(negedge clk);
         if (w == TO) begin
            chk("tie_valid", mem_valid, 1);
            chk("tie_rdata", mem_rdata, 32'h3C3C_A5A5);
            mem_rd = 1'b0;
         end
         chk("tie_err", timeout_err, 0);
         bus_rvalid = w == TO - 1;
         bus_rdata = 32'h3C3C_A5A5;
      end
`else
      for (int w = 1; w <= 20; w++) begin
         @(negedge clk);
         chk("tmo_valid", mem_valid, 0);
         chk("tmo_req", bus_req, 0);
         chk("tmo_stall", stall_mem, 1);
         chk("tmo_err", timeout_err, 0);
      end
      mem_rd = 1'b0;
`endif
      rst_n = 1'b0;
      @(negedge clk);
      chk_all_zero("final_rst");
      rst_n = 1'b1;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single unified memory port between instruction fetch (IF) and the MEM-stage load/store, which is driven from the EX/MEM register outputs (MemRead, MemWrite, alu_result as address, rs2_rdata as store data).
- Sequences each bus transaction through request, grant and response phases.
- Returns read data or a write acknowledge to the owning requester.
- Generates per-requester stall signals that the pipeline registers use as hold enables.

Parameters:
- ADDR_W, 32, address width of requesters and bus.
- DATA_W, 32, data width of requesters and bus.
- TIMEOUT_CYC, 255, maximum WAIT-state cycles before abort; only used when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- sys_clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch request; held until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction.
- if_valid_o  out  1  one-cycle completion pulse for IF.
- mem_rd_i  in  1  load request (MemRead from EX/MEM).
- mem_wr_i  in  1  store request (MemWrite from EX/MEM).
- mem_addr_i  in  ADDR_W  load/store address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data.
- mem_valid_o  out  1  one-cycle completion pulse for MEM.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_gnt_i  in  1  bus accepted the request this cycle.
- bus_rvalid_i  in  1  response/ack this cycle.
- bus_rdata_i  in  DATA_W  response data.
- stall_if_o  out  1  hold the IF stage.
- stall_mem_o  out  1  hold the MEM stage and all upstream stages.
- timeout_err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n_i low): state IDLE, owner MEM.
  - bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o are 0.
  - if_rdata_o, mem_rdata_o are 0; if_valid_o, mem_valid_o are 0.
  - timeout_err_o is 0.
  - Reset mid-transaction drops bus_req_o immediately. A late bus_rvalid_i arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE → REQ when any request is present. Requester selection:
    - MEM has fixed priority: mem_rd_i | mem_wr_i beats if_req_i, because it is the older instruction.
    - On entry to REQ, the owner is recorded and bus_addr_o/bus_we_o/bus_wdata_o are registered from the owner's inputs.
    - bus_we_o = mem_wr_i for MEM, 0 for IF.
    - If mem_rd_i and mem_wr_i are both high, the write is performed.
  - REQ: bus_req_o = 1; address and data are held stable. → WAIT on the cycle bus_gnt_i = 1. bus_req_o drops on WAIT entry. bus_rvalid_i is ignored in REQ.
  - WAIT: → DONE on bus_rvalid_i = 1, capturing bus_rdata_i into the owner's rdata register. The other rdata register is unchanged. For writes, rdata is not updated.
  - DONE: the owner's valid pulse is high for exactly 1 cycle. → IDLE unconditionally.
    - DONE exists so the completing requester, still holding its request, is not re-granted. New inputs are sampled in IDLE.
- Minimum latency: request seen in IDLE at cycle N, then REQ with gnt at N+1, WAIT with rvalid at N+2, valid pulse at N+3.
- Stalls (combinational):
  - stall_mem_o = (mem_rd_i | mem_wr_i) & ~(state==DONE & owner==MEM).
  - stall_if_o = if_req_i & ~(state==DONE & owner==IF).
- Requester rules: a requester holds its request and operands stable until its valid pulse. Changing operands before then is not supported. Dropping the request before completion does not cancel the bus transaction; the result is discarded by the pipeline.
- Only one transaction is outstanding at a time. There is no pipelining of bus requests.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8+ bit counter (width = clog2(TIMEOUT_CYC+1)) is cleared on WAIT entry and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYC without bus_rvalid_i, the FSM goes to DONE. The owner's rdata is loaded with 0, the valid pulse is issued, and timeout_err_o is set.
  - timeout_err_o stays set until reset.
  - If rvalid and timeout occur in the same cycle, rvalid wins and no error is flagged.
- Undefined: no counter is built, WAIT lasts indefinitely, and timeout_err_o is tied to 0.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=0x0000_0010, gnt at REQ cycle 1, rvalid with 0x0051_3023 → if_valid_o pulse at N+3, if_rdata_o=0x0051_3023, stall_if_o low only in the pulse cycle.
- Load/fetch collision: mem_rd_i=1 addr 0x100 and if_req_i=1 in the same cycle → MEM serviced first (bus_addr_o=0x100, bus_we_o=0), then IF with no extra IDLE gap beyond DONE; stall_mem_o high until mem_valid_o.
- Store with delayed grant: mem_wr_i=1, addr 0x200, wdata 0xCAFE_F00D, bus_gnt_i low for 4 cycles → bus_req_o and operands stable for 5 cycles, bus_we_o=1, mem_rdata_o unchanged after ack.
- Reset mid-WAIT: assert rst_n_i=0 in WAIT, then pulse bus_rvalid_i after release → all outputs 0, no valid pulse, state IDLE.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: grant, then no rvalid → valid pulse after 8 WAIT cycles, rdata=0, timeout_err_o=1 and sticky. Without the macro, the same stimulus leaves the FSM in WAIT and timeout_err_o=0.
- Both mem_rd_i and mem_wr_i high → bus_we_o=1.
